// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared RISC-V encoding definitions: instruction format codes, the major
// opcode constants, the canonical NOP word and a small sign-extension helper
// used by the immediate range check.
// -----------------------------------------------------------------------------
package rv_pkg;

   // Instruction format selector; codes 6 and 7 are illegal.
   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_LUI    = 7'b0110111;
   localparam logic [6:0]  OP_REG    = 7'b0110011;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;

   // True when imm[31:msb] are all equal, i.e. imm is the sign extension of
   // imm[msb:0] and survives truncation to msb+1 bits.
   function automatic logic sext_fits(input logic [31:0] imm, input int unsigned msb);
      logic [31:0] mask;
      logic [31:0] upper;
      mask  = 32'hFFFF_FFFF << msb;
      upper = imm & mask;
      return (upper == 32'h0000_0000) || (upper == mask);
   endfunction

endpackage

// File: rtl/inst_pack.sv
// -----------------------------------------------------------------------------
// inst_pack
// Combinational field packer: places opcode, register, funct and immediate
// fields into a 32-bit RISC-V instruction word according to the format.
// Illegal formats produce a NOP with err set.
//
// Optional build macro: INST_ENCODER_IMM_CHECK_EN -- when defined, err also
// flags immediates that cannot be represented in the chosen format (the
// truncated word is still produced).
//
// Ports:
//   fmt     in  3   format code (fmt_e)
//   opcode  in  7   opcode, bits [6:0]
//   rd      in  5   destination register
//   rs1     in  5   source register 1
//   rs2     in  5   source register 2
//   funct3  in  3   funct3 field
//   funct7  in  7   funct7 field (R only)
//   imm     in  32  sign-extended byte-offset immediate
//   inst    out 32  encoded instruction
//   err     out 1   encoding error
// -----------------------------------------------------------------------------
module inst_pack
   import rv_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        err
);

   logic fmt_bad_s;
   logic imm_bad_s;

   // Scatter fields into the word for each format.
   always_comb begin
      inst      = NOP_INST;
      fmt_bad_s = 1'b0;
      case (fmt)
         FMT_R:   inst = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I:   inst = {imm[11:0], rs1, funct3, rd, opcode};
         FMT_S:   inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B:   inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         FMT_U:   inst = {imm[31:12], rd, opcode};
         FMT_J:   inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: begin
            inst      = NOP_INST;
            fmt_bad_s = 1'b1;
         end
      endcase
   end

`ifdef INST_ENCODER_IMM_CHECK_EN
   // Flag immediates whose upper bits or alignment would be lost.
   always_comb begin
      imm_bad_s = 1'b0;
      case (fmt)
         FMT_I, FMT_S: imm_bad_s = !sext_fits(imm, 11);
         FMT_B:        imm_bad_s = !sext_fits(imm, 12) || imm[0];
         FMT_J:        imm_bad_s = !sext_fits(imm, 20) || imm[0];
         FMT_U:        imm_bad_s = (imm[11:0] != 12'h000);
         default:      imm_bad_s = 1'b0;
      endcase
   end
`else
   assign imm_bad_s = 1'b0;
`endif

   assign err = fmt_bad_s | imm_bad_s;

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Registered valid/ready stage around inst_pack. Each accepted field bundle
// becomes one instruction word one cycle later, tagged with a sequential
// word address that wraps at DEPTH. enc_count counts output handshakes.
//
// Optional build macro: INST_ENCODER_IMM_CHECK_EN (immediate range checking
// inside inst_pack).
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush            synchronous clear of output stage, address and count
//   in_valid/ready   input stream handshake
//   in_fmt..in_imm   decoded instruction fields
//   out_valid/ready  output stream handshake
//   out_inst         encoded instruction
//   out_addr         word address of out_inst
//   out_err          encoding error for out_inst
//   enc_count        saturating count of output handshakes
// -----------------------------------------------------------------------------
module inst_encoder
   import rv_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_fmt,
   input  logic [6:0]         in_opcode,
   input  logic [4:0]         in_rd,
   input  logic [4:0]         in_rs1,
   input  logic [4:0]         in_rs2,
   input  logic [2:0]         in_funct3,
   input  logic [6:0]         in_funct7,
   input  logic [31:0]        in_imm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_inst,
   output logic [ADDR_W-1:0]  out_addr,
   output logic               out_err,
   output logic [COUNT_W-1:0] enc_count
);

   logic [31:0]       pack_inst_s;
   logic              pack_err_s;
   logic              accept_s;
   logic              out_hs_s;
   logic [ADDR_W-1:0] next_addr_r;
   logic [ADDR_W-1:0] addr_inc_s;

   inst_pack u_pack (
      .fmt    (in_fmt),
      .opcode (in_opcode),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .funct3 (in_funct3),
      .funct7 (in_funct7),
      .imm    (in_imm),
      .inst   (pack_inst_s),
      .err    (pack_err_s)
   );

   assign in_ready = !flush && (!out_valid || out_ready);
   assign accept_s = in_valid && in_ready;
   assign out_hs_s = out_valid && out_ready;

   // Address that follows next_addr_r, wrapping at DEPTH-1.
   always_comb begin
      if (next_addr_r == ADDR_W'(DEPTH - 1)) begin
         addr_inc_s = {ADDR_W{1'b0}};
      end else begin
         addr_inc_s = next_addr_r + ADDR_W'(1);
      end
   end

   // Output stage, address counter and handshake counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_inst    <= 32'h0000_0000;
         out_addr    <= {ADDR_W{1'b0}};
         out_err     <= 1'b0;
         enc_count   <= {COUNT_W{1'b0}};
         next_addr_r <= {ADDR_W{1'b0}};
      end else if (flush) begin
         out_valid   <= 1'b0;
         out_inst    <= 32'h0000_0000;
         out_addr    <= {ADDR_W{1'b0}};
         out_err     <= 1'b0;
         enc_count   <= {COUNT_W{1'b0}};
         next_addr_r <= {ADDR_W{1'b0}};
      end else begin
         if (out_hs_s) begin
            next_addr_r <= addr_inc_s;
            if (enc_count != {COUNT_W{1'b1}}) begin
               enc_count <= enc_count + COUNT_W'(1);
            end
         end
         if (accept_s) begin
            out_valid <= 1'b1;
            out_inst  <= pack_inst_s;
            out_err   <= pack_err_s;
            // A word loaded in the same cycle as a handshake takes the
            // address after the one just consumed.
            out_addr  <= out_hs_s ? addr_inc_s : next_addr_r;
         end else if (out_hs_s) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
// Self-checking bench for inst_encoder (DEPTH=4): directed vectors followed by
// randomized traffic compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_inst_encoder;
   import rv_pkg::*;

   localparam int DEPTH   = 4;
   localparam int ADDR_W  = 2;
   localparam int COUNT_W = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [2:0]         in_fmt;
   logic [6:0]         in_opcode;
   logic [4:0]         in_rd;
   logic [4:0]         in_rs1;
   logic [4:0]         in_rs2;
   logic [2:0]         in_funct3;
   logic [6:0]         in_funct7;
   logic [31:0]        in_imm;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        out_inst;
   logic [ADDR_W-1:0]  out_addr;
   logic               out_err;
   logic [COUNT_W-1:0] enc_count;

   always #5 clk = ~clk;

   inst_encoder #(.DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_addr  (out_addr),
      .out_err   (out_err),
      .enc_count (enc_count)
   );

   typedef struct {
      logic [31:0] inst;
      logic        err;
      int          addr;
   } exp_t;

   exp_t exp_q[$];
   int   hs_total = 0;   // output handshakes since reset/flush
   int   n_vec    = 0;
   int   n_miss   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: instruction word and error flag straight from the format rules.
   function automatic logic [32:0] ref_encode(input logic [2:0] fmt, input logic [6:0] opc,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [31:0] imm);
      logic [31:0] w;
      logic        e;
      int          simm;
      simm = $signed(imm);
      e    = 1'b0;
      w    = 32'h0000_0000;
      case (fmt)
         3'd0: w = {f7, rs2, rs1, f3, rd, opc};
         3'd1: begin
            w = {imm[11:0], rs1, f3, rd, opc};
`ifdef INST_ENCODER_IMM_CHECK_EN
            e = (simm < -2048) || (simm > 2047);
`endif
         end
         3'd2: begin
            w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
`ifdef INST_ENCODER_IMM_CHECK_EN
            e = (simm < -2048) || (simm > 2047);
`endif
         end
         3'd3: begin
            w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
`ifdef INST_ENCODER_IMM_CHECK_EN
            e = (simm < -4096) || (simm > 4095) || (simm % 2 != 0);
`endif
         end
         3'd4: begin
            w = {imm[31:12], rd, opc};
`ifdef INST_ENCODER_IMM_CHECK_EN
            e = (imm % 32'd4096) != 32'd0;
`endif
         end
         3'd5: begin
            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
`ifdef INST_ENCODER_IMM_CHECK_EN
            e = (simm < -1048576) || (simm > 1048575) || (simm % 2 != 0);
`endif
         end
         default: begin
            w = 32'h0000_0013;
            e = 1'b1;
         end
      endcase
      return {e, w};
   endfunction

   task automatic check_outputs();
      int cnt_exp;
      check_eq("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
      if (exp_q.size() != 0) begin
         check_eq("out_inst", out_inst, exp_q[0].inst);
         check_eq("out_err", {31'd0, out_err}, {31'd0, exp_q[0].err});
         check_eq("out_addr", {30'd0, out_addr}, 32'(exp_q[0].addr));
      end
      cnt_exp = (hs_total > 65535) ? 65535 : hs_total;
      check_eq("enc_count", {16'd0, enc_count}, 32'(cnt_exp));
   endtask

   // One clock: check in_ready, update the model from the handshakes, advance.
   task automatic step();
      logic        rdy_exp;
      logic        hs;
      logic        acc;
      logic [32:0] r;
      exp_t        e;
      #1;
      rdy_exp = !flush && (!out_valid || out_ready);
      check_eq("in_ready", {31'd0, in_ready}, {31'd0, rdy_exp});
      hs  = out_valid && out_ready;
      acc = in_valid && in_ready;
      if (flush) begin
         exp_q.delete();
         hs_total = 0;
      end else begin
         if (hs && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            hs_total++;
         end
         if (acc) begin
            r      = ref_encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
            e.err  = r[32];
            e.inst = r[31:0];
            e.addr = hs_total % DEPTH;
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic set_fields(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [31:0] imm);
      in_fmt    = fmt;
      in_opcode = opc;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct3 = f3;
      in_funct7 = 7'h55;
      in_imm    = imm;
   endtask

   // Issue one word with out_ready=1 and compare against a known encoding.
   task automatic issue(input string tag, input logic [2:0] fmt, input logic [6:0] opc,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [31:0] imm,
                        input logic [31:0] exp_inst, input logic exp_err, input int exp_addr);
      set_fields(fmt, opc, rd, rs1, rs2, f3, imm);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      check_eq({tag, "_inst"}, out_inst, exp_inst);
      check_eq({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
      check_eq({tag, "_addr"}, {30'd0, out_addr}, 32'(exp_addr));
   endtask

   initial begin
      logic        imm_chk_err;
      logic [31:0] r32;
`ifdef INST_ENCODER_IMM_CHECK_EN
      imm_chk_err = 1'b1;
`else
      imm_chk_err = 1'b0;
`endif
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
      #12;
      check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_inst", out_inst, 32'd0);
      check_eq("rst_count", {16'd0, enc_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back directed words; addresses wrap at DEPTH=4.
      issue("i_addi", 3'd1, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 32'd5,          32'h0050_0093, 1'b0, 0);
      issue("s_sw",   3'd2, OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 32'd8,          32'h0020_A423, 1'b0, 1);
      issue("b_beq",  3'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC,  32'hFE00_0EE3, 1'b0, 2);
      issue("j_jal",  3'd5, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 32'd8,          32'h0080_00EF, 1'b0, 3);
      issue("j_odd",  3'd5, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 32'd7,          32'h0060_00EF, imm_chk_err, 0);
      issue("i_big",  3'd1, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,       32'h8000_0093, imm_chk_err, 1);
      issue("fmt7",   3'd7, OP_IMM,    5'd3, 5'd4, 5'd5, 3'd1, 32'd1,          32'h0000_0013, 1'b1, 2);
      in_valid = 1'b0;
      step();

      // Backpressure: word held stable, in_ready low.
      set_fields(3'd4, OP_LUI, 5'd7, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      step();
      set_fields(3'd0, OP_REG, 5'd2, 5'd3, 5'd4, 3'd0, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("bp_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();

      // Flush with a held word and in_valid=1.
      set_fields(3'd1, OP_LOAD, 5'd9, 5'd8, 5'd0, 3'd2, 32'd16);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
      check_eq("flush_count", {16'd0, enc_count}, 32'd0);
      issue("post_flush", 3'd4, OP_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_1000, 32'h0000_10B7, 1'b0, 0);

      // Asynchronous reset mid-cycle while a word is held.
      out_ready = 1'b0;
      in_valid  = 1'b0;
      step();
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
      check_eq("arst_inst", out_inst, 32'd0);
      check_eq("arst_addr", {30'd0, out_addr}, 32'd0);
      check_eq("arst_err", {31'd0, out_err}, 32'd0);
      check_eq("arst_count", {16'd0, enc_count}, 32'd0);
      exp_q.delete();
      hs_total = 0;
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         r32 = $urandom;
         in_fmt    = 3'($urandom_range(0, 7));
         in_opcode = r32[6:0];
         in_rd     = r32[11:7];
         in_rs1    = r32[16:12];
         in_rs2    = r32[21:17];
         in_funct3 = r32[24:22];
         in_funct7 = r32[31:25];
         case ($urandom_range(0, 3))
            0:       in_imm = $urandom;
            1:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       in_imm = $urandom & 32'hFFFF_F000;
            default: in_imm = 32'($urandom_range(0, 4095)) << 1;
         endcase
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 29) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
